// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int          XLEN    = 32;
    localparam logic [31:0] DIV0_Q  = 32'hFFFFFFFF;
    localparam logic [31:0] INT_MIN = 32'h80000000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } md_state_e;

endpackage

// File: rtl/muldiv.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-divide steps on a
// shared 64-bit register, then one sign-fix cycle.
module muldiv
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            Start,
    input  logic [2:0]      MDControl,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result
);

    md_state_e   state, nstate;
    md_op_e      op, in_op;
    logic [4:0]  cnt;
    logic [63:0] acc;          // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] opnd;         // multiplicand or divisor magnitude
    logic        neg_q, neg_r, spec_pend;

    logic        accept, a_sgn, b_sgn, div0, ovf, special;
    logic [31:0] abs_a, abs_b, spec_val, fix_val, q_fix, r_fix;
    logic [32:0] mul_sum, trial;
    logic [63:0] mul_nxt, div_nxt, prod_fix;

    assign in_op   = md_op_e'(MDControl);
    assign accept  = Start && ((state == S_IDLE && !spec_pend) || state == S_DONE);
    assign a_sgn   = (in_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && A[31];
    assign b_sgn   = (in_op inside {OP_MULH, OP_DIV, OP_REM}) && B[31];
    assign abs_a   = a_sgn ? -A : A;
    assign abs_b   = b_sgn ? -B : B;
    assign div0    = MDControl[2] && (B == '0);
    assign ovf     = (in_op == OP_DIV || in_op == OP_REM) && A == INT_MIN && B == 32'hFFFFFFFF;
    assign special = div0 || ovf;

    // bit 1 of the op separates remainder from quotient within the divide group
    always_comb begin
        spec_val = '0;
        if (div0)     spec_val = MDControl[1] ? A : DIV0_Q;
        else if (ovf) spec_val = MDControl[1] ? 32'h0 : INT_MIN;
    end

    assign mul_sum = {1'b0, acc[63:32]} + {1'b0, opnd};
    assign mul_nxt = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};
    assign trial   = acc[63:31] - {1'b0, opnd};
    assign div_nxt = trial[32] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1};

    assign prod_fix = neg_q ? -acc : acc;
    assign q_fix    = neg_q ? -acc[31:0]  : acc[31:0];
    assign r_fix    = neg_r ? -acc[63:32] : acc[63:32];

    always_comb begin
        fix_val = prod_fix[63:32];
        case (op)
            OP_MUL:          fix_val = prod_fix[31:0];
            OP_DIV, OP_DIVU: fix_val = q_fix;
            OP_REM, OP_REMU: fix_val = r_fix;
            default:         fix_val = prod_fix[63:32];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nstate;
    end

    // a special-case op waits one cycle in IDLE (spec_pend) so Done lands on the following edge
    always_comb begin
        nstate = state;
        case (state)
            S_IDLE: if (spec_pend)   nstate = S_DONE;
                    else if (accept) nstate = special ? S_IDLE : S_RUN;
            S_RUN:  if (cnt == 5'd0) nstate = S_FIX;
            S_FIX:  nstate = S_DONE;
            S_DONE: nstate = accept ? (special ? S_IDLE : S_RUN) : S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op        <= OP_MUL;
            cnt       <= '0;
            acc       <= '0;
            opnd      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            spec_pend <= 1'b0;
            Result    <= '0;
        end else if (accept) begin
            op        <= in_op;
            opnd      <= abs_b;
            neg_q     <= a_sgn ^ b_sgn;
            neg_r     <= a_sgn;
            cnt       <= 5'd31;
            spec_pend <= special;
            acc       <= {32'h0, special ? spec_val : abs_a};
        end else begin
            case (state)
                S_IDLE: if (spec_pend) begin
                    Result    <= acc[31:0];
                    spec_pend <= 1'b0;
                end
                S_RUN: begin
                    acc <= op[2] ? div_nxt : mul_nxt;
                    if (cnt != 5'd0) cnt <= cnt - 5'd1;
                end
                S_FIX:   Result <= fix_val;
                default: ;
            endcase
        end
    end

    assign Busy = (state == S_RUN) || (state == S_FIX);
    assign Done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed spec vectors, special cases, random ops
// against an arithmetic reference, Start handling and asynchronous reset.
module tb_muldiv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Start;
    logic [2:0]  MDControl;
    logic [31:0] A, B;
    logic        Busy, Done;
    logic [31:0] Result;

    int checks   = 0;
    int failures = 0;

    muldiv dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .MDControl(MDControl),
        .A(A), .B(B), .Busy(Busy), .Done(Done), .Result(Result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return (op[2] && b == 0) || ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF);
    endfunction

    // Issues one op and observes it to Done; returns result, edges after acceptance, busy samples, overlap flag.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_n, output bit overlap);
        @(negedge clk);
        MDControl = op; A = a; B = b; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0; A = $urandom; B = $urandom; MDControl = 3'($urandom);
        lat = 0; busy_n = 0; overlap = 0;
        if (Busy) busy_n++;
        while (!Done && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (Busy && Done) overlap = 1;
            if (Busy && !Done) busy_n++;
        end
        res = Result;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; Start = 1'b0; MDControl = 3'd0; A = '0; B = '0;
        #2;
        checks++; if (Busy !== 1'b0)    begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        checks++; if (Done !== 1'b0)    begin failures++; $display("FAIL reset_done got=%b exp=0", Done); end
        checks++; if (Result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", Result); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [2:0]  ops[13]  = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
        logic [31:0] as[13]   = '{32'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                  32'h12345678, 32'h12345678, 32'h80000000, 32'h80000000};
        logic [31:0] bs[13]   = '{32'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                  32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exps[13] = '{32'h18, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1,
                                  32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h1,
                                  32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'h0};
        int          lats[13] = '{33, 33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
        logic [31:0] res;
        int          lat, busy_n;
        bit          ov;
        for (int i = 0; i < 13; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, busy_n, ov);
            checks++; if (res !== exps[i]) begin failures++; $display("FAIL dir_result[%0d] got=%h exp=%h", i, res, exps[i]); end
            checks++; if (lat != lats[i])  begin failures++; $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, lat, lats[i]); end
            checks++; if (busy_n != ((lats[i] == 33) ? 33 : 0) || ov)
                begin failures++; $display("FAIL dir_busy[%0d] busy_cycles=%0d overlap=%0d", i, busy_n, ov); end
        end
        @(posedge clk); #1;
        checks++; if (Done !== 1'b0)    begin failures++; $display("FAIL done_pulse got=%b exp=0", Done); end
        checks++; if (Result !== 32'h0) begin failures++; $display("FAIL result_hold got=%h exp=0", Result); end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, res, exp;
        int          lat, busy_n, el;
        bit          ov;
        for (int i = 0; i < 48; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            exp = ref_md(op, a, b);
            el  = is_special(op, a, b) ? 1 : 33;
            run_op(op, a, b, res, lat, busy_n, ov);
            checks++; if (res !== exp || lat != el || ov)
                begin failures++; $display("FAIL rand[%0d] op=%0d a=%h b=%h got=%h exp=%h lat=%0d exp_lat=%0d", i, op, a, b, res, exp, lat, el); end
        end
    endtask

    task automatic test_start_ignored();
        int lat = 0;
        @(negedge clk);
        MDControl = 3'd0; A = 32'd1000; B = 32'd3; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        while (!Done && lat < 60) begin
            if (lat == 5) begin
                @(negedge clk);
                Start = 1'b1; MDControl = 3'd5; A = 32'd77; B = 32'd7;
            end
            @(posedge clk); #1;
            lat++;
            if (lat == 6) Start = 1'b0;
        end
        checks++; if (Result !== 32'd3000) begin failures++; $display("FAIL ignore_result got=%h exp=%h", Result, 32'd3000); end
        checks++; if (lat != 33)           begin failures++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        @(negedge clk);
        MDControl = 3'd3; A = 32'hDEADBEEF; B = 32'h12345678; Start = 1'b1;
        @(posedge clk); #1;
        MDControl = 3'd6; A = 32'hFFFF8001; B = 32'd1234;
        while (!Done && lat < 60) begin @(posedge clk); #1; lat++; end
        checks++; if (Result !== ref_md(3'd3, 32'hDEADBEEF, 32'h12345678) || lat != 33)
            begin failures++; $display("FAIL b2b_first got=%h exp=%h lat=%0d", Result, ref_md(3'd3, 32'hDEADBEEF, 32'h12345678), lat); end
        @(posedge clk); #1;
        Start = 1'b0;
        lat = 0;
        checks++; if (Busy !== 1'b1 || Done !== 1'b0) begin failures++; $display("FAIL b2b_accept busy=%b done=%b", Busy, Done); end
        while (!Done && lat < 60) begin @(posedge clk); #1; lat++; end
        checks++; if (Result !== ref_md(3'd6, 32'hFFFF8001, 32'd1234) || lat != 33)
            begin failures++; $display("FAIL b2b_second got=%h exp=%h lat=%0d", Result, ref_md(3'd6, 32'hFFFF8001, 32'd1234), lat); end
    endtask

    task automatic test_async_reset();
        bit          seen = 0;
        logic [31:0] res;
        int          lat, busy_n;
        bit          ov;
        @(negedge clk);
        MDControl = 3'd4; A = 32'h7654321; B = 32'd9; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin failures++; $display("FAIL arst_busy busy=%b done=%b exp=0", Busy, Done); end
        checks++; if (Result !== 32'h0) begin failures++; $display("FAIL arst_result got=%h exp=0", Result); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; if (Done || Busy) seen = 1; end
        checks++; if (seen) begin failures++; $display("FAIL arst_no_done activity after reset"); end
        run_op(3'd0, 32'd6, 32'd4, res, lat, busy_n, ov);
        checks++; if (res !== 32'h18 || lat != 33) begin failures++; $display("FAIL arst_recover got=%h exp=18 lat=%0d", res, lat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
